// File: rtl/load_writeback_unit.sv
// load_writeback_unit
//   Final pipeline stage: accepts one op per cycle from execute, writes ALU
//   results straight back, and for loads issues a word-aligned memory read,
//   extracts the addressed byte/half/word and writes it to the register file.
//   Misaligned or illegal loads produce a one-cycle load_err and no write.
//
// Ports
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   ex_valid/ex_ready   op handshake from execute (ready only in IDLE/WB)
//   ex_rd, ex_result    destination register, ALU result or load byte address
//   ex_is_load          op is a load; ex_funct3 gives RV32I width/sign
//   ex_reg_write        op writes rd
//   mem_req/mem_addr    read request and word-aligned address, held until mem_gnt
//   mem_gnt             request accepted
//   mem_rvalid/rdata    read data return (ignored outside WAIT)
//   RegWrite, WriteRegister, WriteData   registered register-file write port
//   load_err            one-cycle pulse on misaligned/illegal load
module load_writeback_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid,
    output logic        ex_ready,
    input  logic [4:0]  ex_rd,
    input  logic [31:0] ex_result,
    input  logic        ex_is_load,
    input  logic [2:0]  ex_funct3,
    input  logic        ex_reg_write,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        RegWrite,
    output logic [4:0]  WriteRegister,
    output logic [31:0] WriteData,
    output logic        load_err
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        WB
    } state_t;

    state_t      state;
    logic [4:0]  ldRd;
    logic        ldRegWrite;
    logic [2:0]  ldFunct3;
    logic [1:0]  ldOffset;

    logic        accept;
    logic        loadIllegal;
    logic        loadMisaligned;
    logic [7:0]  byteSel;
    logic [15:0] halfSel;
    logic [31:0] loadData;

    assign accept = ex_valid && ex_ready;

    always_comb begin
        loadIllegal    = (ex_funct3 == 3'b011) || (ex_funct3 == 3'b110) ||
                         (ex_funct3 == 3'b111);
        // funct3[1:0]==01 covers both LH and LHU.
        loadMisaligned = ((ex_funct3[1:0] == 2'b01) && ex_result[0]) ||
                         ((ex_funct3 == 3'b010) && (ex_result[1:0] != 2'b00));
    end

    always_comb begin
        byteSel  = '0;
        halfSel  = '0;
        loadData = '0;
        case (ldOffset)
            2'd0:    byteSel = mem_rdata[7:0];
            2'd1:    byteSel = mem_rdata[15:8];
            2'd2:    byteSel = mem_rdata[23:16];
            default: byteSel = mem_rdata[31:24];
        endcase
        halfSel = ldOffset[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (ldFunct3)
            3'b000:  loadData = {{24{byteSel[7]}}, byteSel};
            3'b100:  loadData = {24'd0, byteSel};
            3'b001:  loadData = {{16{halfSel[15]}}, halfSel};
            3'b101:  loadData = {16'd0, halfSel};
            default: loadData = mem_rdata;
        endcase
    end

    // ex_ready is registered: it is set to whether the next state can accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            ex_ready      <= 1'b0;
            mem_req       <= 1'b0;
            mem_addr      <= '0;
            RegWrite      <= 1'b0;
            WriteRegister <= '0;
            WriteData     <= '0;
            load_err      <= 1'b0;
            ldRd          <= '0;
            ldRegWrite    <= 1'b0;
            ldFunct3      <= '0;
            ldOffset      <= '0;
        end else begin
            RegWrite <= 1'b0;
            load_err <= 1'b0;
            case (state)
                IDLE, WB: begin
                    if (accept) begin
                        if (!ex_is_load) begin
                            state         <= WB;
                            ex_ready      <= 1'b1;
                            RegWrite      <= ex_reg_write && (ex_rd != '0);
                            WriteRegister <= ex_rd;
                            WriteData     <= ex_result;
                        end else if (loadIllegal || loadMisaligned) begin
                            state    <= IDLE;
                            ex_ready <= 1'b1;
                            load_err <= 1'b1;
                        end else begin
                            state      <= REQ;
                            ex_ready   <= 1'b0;
                            mem_req    <= 1'b1;
                            mem_addr   <= {ex_result[31:2], 2'b00};
                            ldRd       <= ex_rd;
                            ldRegWrite <= ex_reg_write;
                            ldFunct3   <= ex_funct3;
                            ldOffset   <= ex_result[1:0];
                        end
                    end else begin
                        state    <= IDLE;
                        ex_ready <= 1'b1;
                    end
                end
                REQ: begin
                    if (mem_gnt) begin
                        state   <= WAIT;
                        mem_req <= 1'b0;
                    end
                end
                WAIT: begin
                    if (mem_rvalid) begin
                        state         <= WB;
                        ex_ready      <= 1'b1;
                        RegWrite      <= ldRegWrite && (ldRd != '0);
                        WriteRegister <= ldRd;
                        WriteData     <= loadData;
                    end
                end
                default: begin
                    state    <= IDLE;
                    ex_ready <= 1'b1;
                    mem_req  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_writeback_unit.sv
// tb_load_writeback_unit
//   Drives directed and random ops into load_writeback_unit, acting as the
//   data memory. The driver knows the transaction timing it creates and keeps
//   the expected outputs for the current cycle; a negedge process compares.
module tb_load_writeback_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid;
    logic        ex_ready;
    logic [4:0]  ex_rd;
    logic [31:0] ex_result;
    logic        ex_is_load;
    logic [2:0]  ex_funct3;
    logic        ex_reg_write;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        RegWrite;
    logic [4:0]  WriteRegister;
    logic [31:0] WriteData;
    logic        load_err;

    always #5 clk = ~clk;

    load_writeback_unit dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ex_valid     (ex_valid),
        .ex_ready     (ex_ready),
        .ex_rd        (ex_rd),
        .ex_result    (ex_result),
        .ex_is_load   (ex_is_load),
        .ex_funct3    (ex_funct3),
        .ex_reg_write (ex_reg_write),
        .mem_req      (mem_req),
        .mem_addr     (mem_addr),
        .mem_gnt      (mem_gnt),
        .mem_rvalid   (mem_rvalid),
        .mem_rdata    (mem_rdata),
        .RegWrite     (RegWrite),
        .WriteRegister(WriteRegister),
        .WriteData    (WriteData),
        .load_err     (load_err)
    );

    int unsigned nTests = 0;
    int unsigned nFail  = 0;
    bit          checkEn = 1'b0;

    // expected outputs for the current cycle
    logic        eReady, eMemReq, eRW, eErr;
    logic [31:0] eMemAddr, eWD;
    logic [4:0]  eWR;

    function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
        nTests++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endfunction

    always @(negedge clk) begin
        if (checkEn) begin
            check("ex_ready", {31'd0, ex_ready}, {31'd0, eReady});
            check("mem_req", {31'd0, mem_req}, {31'd0, eMemReq});
            check("RegWrite", {31'd0, RegWrite}, {31'd0, eRW});
            check("load_err", {31'd0, load_err}, {31'd0, eErr});
            check("WriteRegister", {27'd0, WriteRegister}, {27'd0, eWR});
            check("WriteData", WriteData, eWD);
            if (eMemReq || !rst_n)
                check("mem_addr", mem_addr, eMemAddr);
        end
    end

    // Reference extraction from the RV32I load rules, by shifting and masking.
    function automatic logic [31:0] extract(logic [31:0] w, logic [31:0] addr, logic [2:0] f3);
        logic [31:0] v;
        int unsigned off;
        off = addr % 4;
        if (f3[1:0] == 2'b00) begin
            v = (w >> (8 * off)) & 32'hFF;
            if (f3 == 3'b000 && v >= 128) v = v - 32'd256;
        end else if (f3[1:0] == 2'b01) begin
            v = (w >> (16 * (off / 2))) & 32'hFFFF;
            if (f3 == 3'b001 && v >= 32768) v = v - 32'd65536;
        end else begin
            v = w;
        end
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idleCycle();
        ex_valid     = 1'b0;
        ex_rd        = 5'($urandom);
        ex_result    = $urandom;
        ex_is_load   = 1'($urandom);
        ex_funct3    = 3'($urandom);
        ex_reg_write = 1'($urandom);
        step();
        eRW = 1'b0; eErr = 1'b0; eReady = 1'b1; eMemReq = 1'b0;
    endtask

    // Issue one op in the current (ready) cycle and play the memory side.
    // Returns in the cycle where the op is in writeback (or the error cycle).
    task automatic doOp(input bit isLoad, input logic [2:0] f3, input logic [31:0] res,
                        input logic [4:0] rd, input bit rw, input int unsigned gntDly,
                        input int unsigned rvDly, input logic [31:0] rdata);
        bit          bad;
        int unsigned sz;
        ex_valid     = 1'b1;
        ex_is_load   = isLoad;
        ex_funct3    = f3;
        ex_result    = res;
        ex_rd        = rd;
        ex_reg_write = rw;
        step();
        ex_valid     = 1'b0;
        ex_rd        = 5'($urandom);
        ex_result    = $urandom;
        sz  = (f3[1:0] == 2'b00) ? 1 : ((f3[1:0] == 2'b01) ? 2 : 4);
        bad = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7) || ((res % sz) != 0);
        eErr = 1'b0; eRW = 1'b0;
        if (!isLoad) begin
            eReady = 1'b1; eMemReq = 1'b0;
            eRW = rw && (rd != 0); eWR = rd; eWD = res;
        end else if (bad) begin
            eReady = 1'b1; eMemReq = 1'b0; eErr = 1'b1;
        end else begin
            eReady = 1'b0; eMemReq = 1'b1; eMemAddr = res & 32'hFFFF_FFFC;
            for (int unsigned i = 0; i < gntDly; i++) begin
                mem_gnt    = 1'b0;
                mem_rvalid = 1'($urandom);
                mem_rdata  = $urandom;
                step();
            end
            mem_gnt    = 1'b1;
            mem_rvalid = 1'($urandom);
            step();
            eMemReq = 1'b0;
            for (int unsigned i = 0; i < rvDly; i++) begin
                mem_gnt    = 1'($urandom);
                mem_rvalid = 1'b0;
                mem_rdata  = $urandom;
                step();
            end
            mem_gnt    = 1'b0;
            mem_rvalid = 1'b1;
            mem_rdata  = rdata;
            step();
            mem_rvalid = 1'b0;
            mem_rdata  = $urandom;
            eReady = 1'b1;
            eRW = rw && (rd != 0); eWR = rd; eWD = extract(rdata, res, f3);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        ex_valid = 1'b0; ex_rd = '0; ex_result = '0; ex_is_load = 1'b0;
        ex_funct3 = '0; ex_reg_write = 1'b0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        eReady = 1'b0; eMemReq = 1'b0; eRW = 1'b0; eErr = 1'b0;
        eMemAddr = '0; eWD = '0; eWR = '0;
        checkEn = 1'b1;
        step(); step();
        rst_n = 1'b1;          // reset release cycle: ex_ready still low
        step();
        eReady = 1'b1;

        // ALU op writes the next cycle for one cycle
        doOp(1'b0, 3'b000, 32'h1234_5678, 5'd5, 1'b1, 0, 0, 0);
        check("pin_alu_wd", WriteData, 32'h1234_5678);
        idleCycle();

        // LB at 0x1003, grant after 2 cycles
        ex_valid = 1'b0;
        doOp(1'b1, 3'b000, 32'h0000_1003, 5'd7, 1'b1, 2, 1, 32'h80FF_0000);
        check("pin_lb_wd", WriteData, 32'hFFFF_FF80);
        idleCycle();

        // LHU at 0x2002
        doOp(1'b1, 3'b101, 32'h0000_2002, 5'd9, 1'b1, 0, 0, 32'h8001_0000);
        check("pin_lhu_wd", WriteData, 32'h0000_8001);
        idleCycle();

        // misaligned LW
        doOp(1'b1, 3'b010, 32'h0000_2001, 5'd3, 1'b1, 0, 0, 0);
        check("pin_lw_err", {31'd0, load_err}, 32'd1);
        idleCycle();

        // back-to-back ALU ops rd=1,0,2
        doOp(1'b0, 3'b000, 32'h0000_0011, 5'd1, 1'b1, 0, 0, 0);
        doOp(1'b0, 3'b000, 32'h0000_0022, 5'd0, 1'b1, 0, 0, 0);
        check("pin_rd0_nowrite", {31'd0, RegWrite}, 32'd0);
        doOp(1'b0, 3'b000, 32'h0000_0033, 5'd2, 1'b1, 0, 0, 0);
        idleCycle();

        // reset while waiting for read data, then a late rvalid
        ex_valid = 1'b1; ex_is_load = 1'b1; ex_funct3 = 3'b010;
        ex_result = 32'h0000_0040; ex_rd = 5'd4; ex_reg_write = 1'b1;
        step();
        ex_valid = 1'b0;
        eReady = 1'b0; eMemReq = 1'b1; eMemAddr = 32'h0000_0040;
        mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0;
        eMemReq = 1'b0;
        step();
        rst_n = 1'b0;
        eReady = 1'b0; eMemReq = 1'b0; eRW = 1'b0; eErr = 1'b0;
        eMemAddr = '0; eWD = '0; eWR = '0;
        step(); step();
        rst_n = 1'b1;
        step();
        eReady = 1'b1;
        mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        step();
        mem_rvalid = 1'b0;
        step();
        check("pin_reset_nowrite", {27'd0, WriteRegister}, 32'd0);

        // random traffic
        for (int unsigned n = 0; n < 400; n++) begin
            bit          isLoad;
            logic [4:0]  rd;
            isLoad = 1'($urandom);
            rd = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
            doOp(isLoad, 3'($urandom), $urandom, rd, 1'($urandom),
                 $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
            if ($urandom_range(0, 1) == 0) idleCycle();
        end
        idleCycle();
        idleCycle();

        checkEn = 1'b0;
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
